// File: rtl/sprite_bouncer.sv
// Bouncing-sprite compositor: NUM_SPRITES rectangles move once per frame and
// are overlaid on a background colour through a two-stage pixel pipeline.
module sprite_bouncer #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_W    = 64,
  parameter int unsigned SPRITE_H    = 64,
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned V_ACTIVE    = 768,
  parameter int unsigned COLOR_W     = 12
) (
  input  logic                           pixel_clk_in,
  input  logic                           rst_in,
  input  logic [10:0]                    hcount_in,
  input  logic [9:0]                     vcount_in,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           blank_in,
  input  logic [3:0]                     speed_in,
  input  logic                           pause_in,
  input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_color_in,
  input  logic [COLOR_W-1:0]             bg_color_in,
  output logic [COLOR_W-1:0]             pixel_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           blank_out,
  output logic                           collision_out
);

  generate
    if (H_ACTIVE < NUM_SPRITES * (SPRITE_W + 8) || SPRITE_W > H_ACTIVE || SPRITE_H > V_ACTIVE)
    begin : g_bad_params
      $error("sprite_bouncer: sprite geometry does not fit the active area");
    end
  endgenerate

  localparam logic [11:0] MAX_X = 12'(H_ACTIVE - SPRITE_W);
  localparam logic [11:0] MAX_Y = 12'(V_ACTIVE - SPRITE_H);
  localparam logic [11:0] SW    = 12'(SPRITE_W);
  localparam logic [11:0] SH    = 12'(SPRITE_H);

  logic [10:0] x_q  [NUM_SPRITES];
  logic [10:0] x_d  [NUM_SPRITES];
  logic [9:0]  y_q  [NUM_SPRITES];
  logic [9:0]  y_d  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] dx_q, dx_d, dy_q, dy_d;

  logic [NUM_SPRITES-1:0] hit_d, hit_q;
  logic hs1_q, vs1_q, bl1_q;
  logic [COLOR_W-1:0] pixel_q, pixel_d;
  logic coll_q, coll_d;
  logic hs2_q, vs2_q, bl2_q;

  logic frame_tick, upd;
  logic [11:0] spd12, h12, v12;

  function automatic logic [11:0] next_pos(input logic [11:0] pos, input logic dir,
                                           input logic [11:0] spd, input logic [11:0] lim);
    if (dir) return (pos + spd >= lim) ? lim : pos + spd;
    else     return (pos <= spd) ? 12'd0 : pos - spd;
  endfunction

  function automatic logic next_dir(input logic [11:0] pos, input logic dir,
                                    input logic [11:0] spd, input logic [11:0] lim);
    if (dir) return !(pos + spd >= lim);
    else     return (pos <= spd);
  endfunction

  assign frame_tick = (hcount_in == 11'd0) && ({2'b0, vcount_in} == 12'(V_ACTIVE));
  // Zero speed must not flip a direction bit at a wall, so it disables the update outright.
  assign upd   = frame_tick && !pause_in && (speed_in != 4'd0);
  assign spd12 = {8'b0, speed_in};
  assign h12   = {1'b0, hcount_in};
  assign v12   = {2'b0, vcount_in};

  always_comb begin
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      dx_d[i] = dx_q[i];
      dy_d[i] = dy_q[i];
      if (upd) begin
        x_d[i]  = 11'(next_pos({1'b0, x_q[i]}, dx_q[i], spd12, MAX_X));
        dx_d[i] = next_dir({1'b0, x_q[i]}, dx_q[i], spd12, MAX_X);
        y_d[i]  = 10'(next_pos({2'b0, y_q[i]}, dy_q[i], spd12, MAX_Y));
        dy_d[i] = next_dir({2'b0, y_q[i]}, dy_q[i], spd12, MAX_Y);
      end
    end
  end

  always_comb begin
    hit_d = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      hit_d[i] = (h12 >= {1'b0, x_q[i]}) && (h12 < {1'b0, x_q[i]} + SW) &&
                 (v12 >= {2'b0, y_q[i]}) && (v12 < {2'b0, y_q[i]} + SH);
    end
  end

  always_comb begin
    logic       found;
    logic [3:0] cnt;
    found   = 1'b0;
    cnt     = '0;
    pixel_d = bg_color_in;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      cnt = cnt + {3'b0, hit_q[i]};
      if (hit_q[i] && !found) begin
        pixel_d = sprite_color_in[i*COLOR_W +: COLOR_W];
        found   = 1'b1;
      end
    end
    coll_d = (cnt >= 4'd2) && !bl1_q;
    if (bl1_q) pixel_d = '0;
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]  <= 11'(i * (SPRITE_W + 8));
        y_q[i]  <= '0;
        dx_q[i] <= (i % 2 == 0);
        dy_q[i] <= 1'b1;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_q   <= '0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      bl1_q   <= 1'b0;
      pixel_q <= '0;
      coll_q  <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      bl2_q   <= 1'b0;
    end else begin
      hit_q   <= hit_d;
      hs1_q   <= hsync_in;
      vs1_q   <= vsync_in;
      bl1_q   <= blank_in;
      pixel_q <= pixel_d;
      coll_q  <= coll_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      bl2_q   <= bl1_q;
    end
  end

  assign pixel_out     = pixel_q;
  assign collision_out = coll_q;
  assign hsync_out     = hs2_q;
  assign vsync_out     = vs2_q;
  assign blank_out     = bl2_q;

endmodule

// File: tb/tb_sprite_bouncer.sv
// Bench for sprite_bouncer: directed bounce scenarios plus randomized motion and
// pixel probes compared against a per-frame arithmetic model of the sprites.
module tb_sprite_bouncer;
  localparam int N = 4, W = 64, H = 64, HA = 1024, VA = 768, CW = 12;
  localparam int MAXX = HA - W, MAXY = VA - H;

  logic clk = 1'b0;
  logic rst;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic hs, vs, bl, pause;
  logic [3:0] spd;
  logic [N*CW-1:0] scol;
  logic [CW-1:0] bg, pixel_out;
  logic hsync_out, vsync_out, blank_out, collision_out;

  int checks = 0, errors = 0;
  int mx[N], my[N], mdx[N], mdy[N];

  sprite_bouncer #(.NUM_SPRITES(N), .SPRITE_W(W), .SPRITE_H(H),
                   .H_ACTIVE(HA), .V_ACTIVE(VA), .COLOR_W(CW)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
    .hsync_in(hs), .vsync_in(vs), .blank_in(bl), .speed_in(spd), .pause_in(pause),
    .sprite_color_in(scol), .bg_color_in(bg), .pixel_out(pixel_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .collision_out(collision_out));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = i * (W + 8); my[i] = 0; mdx[i] = (i % 2 == 0); mdy[i] = 1;
    end
  endfunction

  // One frame of bouncing motion on a single axis.
  function automatic void bounce(inout int p, inout int d, input int s, input int lim);
    if (d == 1) begin
      if (p + s >= lim) begin p = lim; d = 0; end else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1; end else p = p - s;
    end
  endfunction

  task automatic tick(input logic p);
    @(negedge clk); hc = 0; vc = 10'(VA); pause = p;
    @(negedge clk); vc = 0; pause = 0;
    if (!p && spd != 0)
      for (int i = 0; i < N; i++) begin
        bounce(mx[i], mdx[i], int'(spd), MAXX);
        bounce(my[i], mdy[i], int'(spd), MAXY);
      end
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic b,
                       output logic [CW-1:0] gp, output logic gc);
    int first, n;
    logic [CW-1:0] ep;
    logic h_s, v_s;
    @(negedge clk);
    hc = 11'(h); vc = 10'(v); bl = b; h_s = 1'($urandom); v_s = 1'($urandom);
    hs = h_s; vs = v_s;
    first = -1; n = 0;
    for (int i = 0; i < N; i++)
      if (h >= mx[i] && h < mx[i] + W && v >= my[i] && v < my[i] + H) begin
        n++;
        if (first < 0) first = i;
      end
    ep = b ? '0 : (first < 0 ? bg : scol[first*CW +: CW]);
    @(negedge clk); @(negedge clk);
    gp = pixel_out; gc = collision_out;
    chk({tag, "_px"}, 32'(pixel_out), 32'(ep));
    chk({tag, "_coll"}, 32'(collision_out), 32'(!b && n >= 2));
    chk({tag, "_sync"}, {29'b0, hsync_out, vsync_out, blank_out}, {29'b0, h_s, v_s, b});
  endtask

  initial begin
    logic [CW-1:0] gp;
    logic gc;
    int k, h, v;
    rst = 1; hc = 5; vc = 5; hs = 1; vs = 1; bl = 0; spd = 0; pause = 0;
    scol = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00}; bg = 12'h000;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_px", 32'(pixel_out), 32'h0);
    chk("reset_coll", 32'(collision_out), 32'h0);
    chk("reset_sync", {29'b0, hsync_out, vsync_out, blank_out}, 32'h0);
    @(negedge clk); rst = 0;

    probe("p00", 0, 0, 0, gp, gc);   chk("p00_lit", 32'(gp), 32'hF00);
    probe("p70", 70, 0, 0, gp, gc);  chk("p70_lit", 32'(gp), 32'h000);
    tick(0);
    probe("spd0", 0, 0, 0, gp, gc);  chk("spd0_lit", 32'(gp), 32'hF00);
    probe("spd0b", 72, 0, 0, gp, gc); chk("spd0b_lit", 32'(gp), 32'h0F0);

    spd = 8; tick(0);
    probe("t1a", 64, 8, 0, gp, gc);  chk("t1a_lit", 32'(gp), 32'hF00); chk("t1a_clit", 32'(gc), 32'h1);
    probe("t1b", 100, 8, 0, gp, gc); chk("t1b_lit", 32'(gp), 32'h0F0); chk("t1b_clit", 32'(gc), 32'h0);

    repeat (8) tick(0);
    probe("t9", 0, 72, 0, gp, gc);    chk("t9_lit", 32'(gp), 32'h0F0);
    probe("t9b", 64, 72, 0, gp, gc);
    tick(0);
    probe("t10", 8, 80, 0, gp, gc);   chk("t10_lit", 32'(gp), 32'h0F0);
    probe("t10b", 7, 80, 0, gp, gc);

    repeat (78) tick(0);
    probe("t88", 704, 767, 0, gp, gc); chk("t88_lit", 32'(gp), 32'hF00);
    probe("t88b", 704, 703, 0, gp, gc);
    repeat (32) tick(0);
    probe("t120", 960, 448, 0, gp, gc);  chk("t120_lit", 32'(gp), 32'hF00);
    probe("t120b", 1023, 511, 0, gp, gc); chk("t120b_lit", 32'(gp), 32'hF00);
    probe("t120c", 959, 448, 0, gp, gc);
    tick(0);
    probe("t121", 952, 440, 0, gp, gc);  chk("t121_lit", 32'(gp), 32'hF00);
    probe("t121b", 1016, 440, 0, gp, gc);

    repeat (3) tick(1);
    probe("pause", 952, 440, 0, gp, gc); chk("pause_lit", 32'(gp), 32'hF00);
    probe("pauseb", 951, 440, 0, gp, gc);
    probe("blank", 952, 440, 1, gp, gc);
    chk("blank_lit", 32'(gp), 32'h0); chk("blank_clit", 32'(gc), 32'h0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom % 3 == 0) begin
        spd = 4'($urandom);
        tick(1'($urandom % 5 == 0));
      end else begin
        k = int'($urandom % N);
        h = mx[k] + int'($urandom_range(0, 67)) - 2;
        v = my[k] + int'($urandom_range(0, 67)) - 2;
        if (h < 0) h = 0;
        if (h > HA - 1) h = HA - 1;
        if (v < 0) v = 0;
        if (v > VA - 1) v = VA - 1;
        probe("rnd", h, v, 1'($urandom % 8 == 0), gp, gc);
      end
    end

    spd = 8;
    repeat (5) tick(0);
    probe("pre_rst", mx[0], my[0], 0, gp, gc);
    @(posedge clk); #2 rst = 1;
    #1;
    chk("arst_px", 32'(pixel_out), 32'h0);
    chk("arst_coll", 32'(collision_out), 32'h0);
    chk("arst_sync", {29'b0, hsync_out, vsync_out, blank_out}, 32'h0);
    model_reset();
    @(negedge clk); @(negedge clk); rst = 0;
    probe("post0", 0, 0, 0, gp, gc);    chk("post0_lit", 32'(gp), 32'hF00);
    probe("post1", 72, 0, 0, gp, gc);   chk("post1_lit", 32'(gp), 32'h0F0);
    probe("post2", 144, 0, 0, gp, gc);  chk("post2_lit", 32'(gp), 32'h00F);
    probe("post3", 216, 63, 0, gp, gc); chk("post3_lit", 32'(gp), 32'hFF0);
    tick(0);
    probe("post_t1", 64, 8, 0, gp, gc); chk("post_t1_lit", 32'(gp), 32'hF00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
